multdiv_sequencer: RTL
======================

# multdiv_sequencer

Execute-stage controller that sequences the multi-cycle multiply/divide unit. It detects R-type `mul`/`div` in X, pulses the unit's start control, and stalls the front of the pipeline until the result returns. It then presents the result (or an `rstatus` exception code) for one cycle so the X/M latch captures it. It sits beside the combinational execute decoder and overrides the ALU result path only for `mul`/`div`.

## Interface
- `TIMEOUT_CYCLES`, default 40: maximum WAIT cycles before forcing a timeout exception.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `ex_valid` in 1: X holds a real instruction, not a bubble.
- `ex_rtype` in 1: X opcode field is 00000.
- `ALU_opcode` in 5: from the execute decoder; 00110 = mul, 00111 = div.
- `flush` in 1: X instruction is killed this cycle.
- `md_result_rdy` in 1: multdiv unit result valid.
- `md_exception` in 1: multdiv unit exception; qualified by `md_result_rdy`.
- `md_result` in 32: multdiv unit result.
- `ctrl_MULT` out 1: one-cycle start pulse, multiply.
- `ctrl_DIV` out 1: one-cycle start pulse, divide.
- `stall` out 1: hold PC, F/D and D/X; X/M unaffected.
- `md_wb_valid` out 1: X/M takes `md_wb_data` instead of the ALU output.
- `md_wb_data` out 32: registered result.
- `md_exc_valid` out 1: write `rstatus_code` to r30 instead of the result to rd.
- `rstatus_code` out 32: 4 = mul exception, 5 = div exception, else 0.
- `busy` out 1: state ≠ IDLE.

## Operation
- `detect` = `ex_valid & ex_rtype & (ALU_opcode==00110 | ALU_opcode==00111) & ~flush`. It is evaluated only in IDLE.
- **IDLE:** on `detect`, assert `ctrl_MULT` or `ctrl_DIV` combinationally, assert `stall`, latch op type, clear counter, and go to WAIT. Otherwise all outputs are 0.
- **WAIT:** `stall`=1 and counter increments each cycle.
  - `flush` → IDLE. Result is discarded and no writeback occurs.
  - Else `md_result_rdy` → capture `md_result` into `md_wb_data`, capture the exception flag, and go to DONE.
  - Else counter == `TIMEOUT_CYCLES` → set exception flag, set `md_wb_data`=0, and go to DONE.
- **DONE:** `stall`=0, `md_wb_valid`=1, and `md_exc_valid` = exception flag. `rstatus_code` = 4 or 5 per latched op when the flag is set, else 0. Always go to IDLE next. `detect` is ignored in DONE because the X instruction is still the completing `mul`/`div`.
- `md_result_rdy` outside WAIT is ignored, including stale assertions in the detect cycle.
- Simultaneous `flush` and `md_result_rdy` in WAIT: `flush` wins.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and it saturates; it never wraps.

## Timing
- Reset (async, mid-operation included): state IDLE, counter 0, `md_wb_data` 0, exception flag 0. All outputs 0. A start pulse in flight is dropped.
- Detect in cycle t0. `md_result_rdy` first sampled in WAIT at t_k (k ≥ 1).
  - DONE is at t_k+1.
  - `stall` is high t0..t_k, which is k+1 cycles.
  - `md_wb_valid` is high exactly at t_k+1.
- Timeout: DONE at t0+`TIMEOUT_CYCLES`+1.
- Back-to-back `mul`/`div`: the next detect is no earlier than DONE+1, so there is at least one IDLE cycle between operations.
- `ctrl_MULT`/`ctrl_DIV` are Mealy outputs: they are high only in the detect cycle and never both high.

## Structure
- `exec_ctrl_pkg` contains:
  - ALU opcode constants (`ALU_MUL`=00110, `ALU_DIV`=00111).
  - `rstatus` codes (`RSTATUS_MUL`=4, `RSTATUS_DIV`=5).
  - R-type opcode constant (00000).
  - State encoding for IDLE/WAIT/DONE.
- Sub-module `md_timeout_counter`: clear, enable, saturating count, and a `hit` output at `TIMEOUT_CYCLES`.

## Test plan
- **mul, unit ready 3 cycles after start, `md_result`=0x0000_0018:**
  - `ctrl_MULT` for 1 cycle.
  - `stall` high 4 cycles.
  - DONE: `md_wb_valid`=1, `md_wb_data`=0x18, `md_exc_valid`=0.
- **div by zero, `md_result_rdy`+`md_exception` at WAIT cycle 2:** in DONE, `md_exc_valid`=1 and `rstatus_code`=5.
- **`flush` at WAIT cycle 2, then `md_result_rdy` asserted:**
  - Returns to IDLE.
  - `md_wb_valid` never asserts and `stall` drops the cycle after the flush.
- **Timeout, `TIMEOUT_CYCLES`=40, `md_result_rdy` never asserted:** DONE at t0+41 with `md_exc_valid`=1 and `rstatus_code`=4 for mul.
- **Back-to-back mul then div:**
  - Exactly one `ctrl_MULT` and one `ctrl_DIV`.
  - `ctrl_DIV` is no earlier than DONE+1 of the mul.
  - Two `md_wb_valid` pulses with the correct data.
- **`reset` asserted mid-WAIT between clock edges:** all outputs 0 immediately, and a later `md_result_rdy` produces no writeback.

Source files
------------

// File: rtl/exec_ctrl_pkg.sv
// Shared constants for the execute-stage control logic.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
package exec_ctrl_pkg;

    // ALU opcodes from the execute decoder that need the multi-cycle unit
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // Primary opcode field value of an R-type instruction
    localparam logic [4:0] OPC_RTYPE = 5'b00000;

    // Exception codes written to r30 when the multdiv unit faults
    localparam logic [31:0] RSTATUS_MUL = 32'd4;
    localparam logic [31:0] RSTATUS_DIV = 32'd5;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // True for the two ALU opcodes that are routed to the multdiv unit
    function automatic logic is_md_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Saturating WAIT-cycle counter with a timeout strobe.
// Latency: hit is combinational from the current count and enable.
// Backpressure: none; clear wins over enable, count holds at the limit.
module md_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;

    // The count after this cycle, saturating at LIMIT so it can never wrap.
    // hit means "this enabled cycle is the TIMEOUT_CYCLES-th one", so the
    // caller can leave its wait state on exactly that cycle.
    always_comb begin
        w_count_nxt = (r_count == LIMIT) ? r_count : r_count + CW'(1);
        hit         = enable && (w_count_nxt == LIMIT);
    end

    // Count register: cleared on a new operation, advanced while waiting
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: rtl/multdiv_sequencer.sv
// Sequences mul/div through the multi-cycle unit and stalls the front end.
// Latency: start pulse in the detect cycle, result presented one cycle after rdy.
// Backpressure: stall held from detect until the result (or timeout) is taken.
module multdiv_sequencer
    import exec_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_rtype,
    input  logic [4:0]  ALU_opcode,
    input  logic        flush,
    input  logic        md_result_rdy,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        md_wb_valid,
    output logic [31:0] md_wb_data,
    output logic        md_exc_valid,
    output logic [31:0] rstatus_code,
    output logic        busy
);

    md_state_t   r_state;
    md_state_t   w_state_nxt;
    logic        r_is_div;
    logic        r_exc;
    logic [31:0] r_data;

    logic        w_detect;
    logic        w_cnt_clr;
    logic        w_cnt_en;
    logic        w_hit;
    logic        w_cap_res;
    logic        w_cap_timeout;

    md_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_cnt_clr),
        .enable (w_cnt_en),
        .hit    (w_hit)
    );

    // Next-state and output decode; outputs are zero unless a state drives them
    always_comb begin
        w_detect      = ex_valid & ex_rtype & is_md_op(ALU_opcode) & ~flush;
        w_state_nxt   = r_state;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        stall         = 1'b0;
        md_wb_valid   = 1'b0;
        md_wb_data    = 32'd0;
        md_exc_valid  = 1'b0;
        rstatus_code  = 32'd0;
        w_cnt_clr     = 1'b0;
        w_cnt_en      = 1'b0;
        w_cap_res     = 1'b0;
        w_cap_timeout = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Unit result handshakes seen here are stale and ignored
                if (w_detect) begin
                    ctrl_MULT   = (ALU_opcode == ALU_MUL);
                    ctrl_DIV    = (ALU_opcode == ALU_DIV);
                    stall       = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall    = 1'b1;
                w_cnt_en = 1'b1;
                // A kill outranks a result arriving in the same cycle
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (md_result_rdy) begin
                    w_cap_res   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_hit) begin
                    w_cap_timeout = 1'b1;
                    w_state_nxt   = ST_DONE;
                end
            end
            ST_DONE: begin
                // X still holds the completing mul/div, so detect is not looked at
                md_wb_valid  = 1'b1;
                md_wb_data   = r_data;
                md_exc_valid = r_exc;
                if (r_exc) begin
                    rstatus_code = r_is_div ? RSTATUS_DIV : RSTATUS_MUL;
                end
                w_state_nxt  = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // The detect-cycle outputs are Mealy; drop them while reset is held
        if (reset) begin
            ctrl_MULT = 1'b0;
            ctrl_DIV  = 1'b0;
            stall     = 1'b0;
        end

        busy = (r_state != ST_IDLE);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operation type, result and exception flag captured for the DONE cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_is_div <= 1'b0;
            r_exc    <= 1'b0;
            r_data   <= 32'd0;
        end else begin
            if (w_cnt_clr) begin
                r_is_div <= (ALU_opcode == ALU_DIV);
                r_exc    <= 1'b0;
            end
            if (w_cap_res) begin
                r_data <= md_result;
                r_exc  <= md_exception;
            end else if (w_cap_timeout) begin
                r_data <= 32'd0;
                r_exc  <= 1'b1;
            end
        end
    end

endmodule
